// File: rtl/int_seq_pkg.sv
// Shared types and constants for the interrupt/reset sequencer.
package int_seq_pkg;

  typedef enum logic [1:0] {
    SRC_RESET,
    SRC_NMI,
    SRC_IRQ
  } int_src_t;

  typedef enum logic [1:0] {
    StRstHold,
    StIdle,
    StInject,
    StService
  } int_state_t;

  localparam logic [15:0] VEC_NMI    = 16'hFFFA;
  localparam logic [15:0] VEC_RESET  = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ    = 16'hFFFE;
  localparam logic [7:0]  BRK_OPCODE = 8'h00;
  localparam int          P_I_BIT    = 2;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous active-low pin; resets to the idle (high) level.
module sync_chain #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Depth-1:0] chain_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '1;
    end else begin
      chain_q <= {chain_q[Depth-2:0], d_i};
    end
  end

  assign q_o = chain_q[Depth-1];

endmodule

// File: rtl/int_seq.sv
// Interrupt/reset sequencer: arbitrates reset > NMI > IRQ at instruction boundaries and injects BRK.
// Define INT_SEQ_IRQ_EN to enable the IRQ path; otherwise only reset, NMI and software BRK vector.
module int_seq
  import int_seq_pkg::*;
#(
  parameter int unsigned NMI_SYNC_STAGES = 2
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        nmi_b,
  input  logic        irq_b,
  input  logic [7:0]  p,
  input  logic        last_cycle,
  input  logic        int_ack,
  input  logic [7:0]  data_in,
  output logic [7:0]  opcode_out,
  output logic        int_active,
  output logic [15:0] vector_addr,
  output logic        brk_flag
);

  int_state_t state_q, state_d;
  int_src_t   src_q, src_d;
  logic       nmi_sync, nmi_prev_q, nmi_edge;
  logic       nmi_pending_q, nmi_pending_d;
  logic       nmi_rearm_q, nmi_rearm_d;
  logic       nmi_service, nmi_ack;
  logic       irq_eligible;
  logic       unused_pins;

  sync_chain #(
    .Depth(NMI_SYNC_STAGES)
  ) u_nmi_sync (
    .clk_i (ph1),
    .rst_ni(reset),
    .d_i   (nmi_b),
    .q_o   (nmi_sync)
  );

`ifdef INT_SEQ_IRQ_EN
  logic irq_sync;

  sync_chain #(
    .Depth(NMI_SYNC_STAGES)
  ) u_irq_sync (
    .clk_i (ph1),
    .rst_ni(reset),
    .d_i   (irq_b),
    .q_o   (irq_sync)
  );

  assign irq_eligible = ~irq_sync & ~p[P_I_BIT];
  assign unused_pins  = ^{p[7:P_I_BIT+1], p[P_I_BIT-1:0]};
`else
  assign irq_eligible = 1'b0;
  assign unused_pins  = ^{p, irq_b};
`endif

  assign nmi_edge    = nmi_prev_q & ~nmi_sync;
  assign nmi_service = ((state_q == StInject) || (state_q == StService)) && (src_q == SRC_NMI);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    nmi_ack = 1'b0;
    case (state_q)
      StRstHold: begin
        state_d = StService;
        src_d   = SRC_RESET;
      end
      StIdle: begin
        if (last_cycle && (nmi_pending_q || irq_eligible)) begin
          src_d   = nmi_pending_q ? SRC_NMI : SRC_IRQ;
          state_d = StInject;
        end
      end
      StInject: state_d = StService;
      StService: begin
        if (int_ack) begin
          state_d = StIdle;
          nmi_ack = (src_q == SRC_NMI);
        end
      end
      default: state_d = StRstHold;
    endcase
  end

  // Edges seen while an NMI is in flight survive the acknowledge and re-arm pending.
  always_comb begin
    nmi_rearm_d   = nmi_service & (nmi_rearm_q | nmi_edge);
    nmi_pending_d = nmi_ack ? (nmi_edge | nmi_rearm_q) : (nmi_pending_q | nmi_edge);
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q       <= StRstHold;
      src_q         <= SRC_RESET;
      nmi_prev_q    <= 1'b1;
      nmi_pending_q <= 1'b0;
      nmi_rearm_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      nmi_prev_q    <= nmi_sync;
      nmi_pending_q <= nmi_pending_d;
      nmi_rearm_q   <= nmi_rearm_d;
    end
  end

  always_comb begin
    opcode_out  = (state_q == StInject) ? BRK_OPCODE : data_in;
    int_active  = (state_q != StIdle);
    vector_addr = VEC_IRQ;
    brk_flag    = 1'b1;
    if (state_q != StIdle) begin
      brk_flag = 1'b0;
      case (src_q)
        SRC_RESET: vector_addr = VEC_RESET;
        SRC_NMI:   vector_addr = VEC_NMI;
        default:   vector_addr = VEC_IRQ;
      endcase
    end
  end

endmodule

// File: doc/int_seq.md
# int_seq

Interrupt and reset sequencer feeding the control FSM's opcode input. It synchronises the NMI and IRQ pins and edge-detects NMI. At each instruction boundary it arbitrates pending requests by priority (reset > NMI > IRQ) and substitutes the BRK opcode (8'h00) for the fetched byte. It then supplies the vector address and pushed-B-flag value that the BRK microcode sequence consumes.

## Interface
Parameters:
- NMI_SYNC_STAGES, 2: synchroniser depth for nmi_b and irq_b; legal range 2–3.

Ports:
- ph1  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately.
- nmi_b  in  1  NMI pin, active-low, asynchronous.
- irq_b  in  1  IRQ pin, active-low, level, asynchronous.
- p  in  8  processor status; bit 2 is I (IRQ mask).
- last_cycle  in  1  from control; high in the final cycle of the current instruction.
- int_ack  in  1  from control; one-cycle pulse when the vector high byte has been loaded into PC.
- data_in  in  8  memory data bus (opcode fetch byte).
- opcode_out  out  8  to control's opcode latch.
- int_active  out  1  high from injection until int_ack.
- vector_addr  out  16  vector low-byte address: FFFA NMI, FFFC reset, FFFE IRQ/BRK.
- brk_flag  out  1  B value to push; 0 for hardware sources, 1 for software BRK.

## Operation
- States: RST_HOLD, IDLE, INJECT, SERVICE.
- RST_HOLD: entered on reset.
  - Source is forced to RESET; int_active=1.
  - Left on the first cycle after reset deasserts, going to SERVICE.
  - The reset sequence is the control FSM's own reset states; no opcode injection takes place.
- IDLE: opcode_out = data_in.
  - If last_cycle=1 and a request is eligible: latch the winning source, go to INJECT.
  - Eligible means nmi_pending, or irq_sync low with p[2]=0.
- INJECT (exactly one cycle): opcode_out = 8'h00; int_active=1; next state is SERVICE.
- SERVICE: opcode_out = data_in; vector_addr and brk_flag held from the latched source.
  - On int_ack, return to IDLE.
  - If the source was NMI, clear nmi_pending on int_ack.
- NMI detection: falling edge of the synchronised nmi_b (previous 1, current 0) sets nmi_pending.
  - A set and a clear in the same cycle: set wins.
  - A new edge during NMI service is retained and serviced next.
- IRQ is level-sensitive and not latched. If irq_b rises before the boundary, no interrupt is taken.
- Priority at a boundary: NMI over IRQ. An IRQ losing arbitration stays eligible for the following boundary.
- Software BRK (opcode 00 fetched from memory in IDLE):
  - Passes through unchanged.
  - vector_addr = FFFE, brk_flag = 1.
  - The block does not enter SERVICE.
- Idle outputs: vector_addr = FFFE, brk_flag = 1.

## Timing
- Reset values:
  - state = RST_HOLD, source = RESET.
  - nmi_pending = 0; synchroniser flops = 1.
  - int_active = 1, vector_addr = 16'hFFFC, brk_flag = 0.
  - opcode_out = data_in (combinational passthrough).
- Pin-to-pending latency: NMI_SYNC_STAGES + 1 cycles from an nmi_b falling edge to nmi_pending=1.
- Eligibility is sampled only in the cycle where last_cycle=1. Injection appears in the immediately following cycle, which is the opcode-fetch cycle.
- opcode_out is a mux selected by registered state; there is no combinational path from pins to outputs.
- int_ack outside SERVICE is ignored.
- Reset asserted mid-SERVICE: state goes to RST_HOLD asynchronously and any pending NMI is discarded.

## Configuration
- INT_SEQ_IRQ_EN defined: IRQ path as specified.
- Not defined:
  - irq_b is unconnected internally and the IRQ synchroniser is removed.
  - Only reset, NMI and software BRK are vectored.
  - vector FFFE is still driven for BRK.

## Structure
- Shared package holds:
  - enum int_src_t {SRC_RESET, SRC_NMI, SRC_IRQ};
  - enum int_state_t;
  - constants VEC_NMI = 16'hFFFA, VEC_RESET = 16'hFFFC, VEC_IRQ = 16'hFFFE, BRK_OPCODE = 8'h00, P_I_BIT = 2.
- One sub-module, `sync_chain` (parameterised depth, reset value 1), instantiated once per pin.

## Test plan
- Release reset, then pulse int_ack → int_active 1→0; vector_addr reads FFFC until the ack; state returns to IDLE.
- nmi_b 1→0 held, then last_cycle pulse ≥4 cycles later → next cycle opcode_out = 00, vector_addr = FFFA, brk_flag = 0. After int_ack, no second injection while nmi_b stays low.
- irq_b low with p = 8'h04 and repeated last_cycle → no injection. Change p to 8'h00 → next boundary injects 00 with vector FFFE and brk_flag = 0.
- irq_b and an nmi_b edge both present at one boundary → NMI serviced first (FFFA). After int_ack, the next boundary services IRQ (FFFE).
- A second nmi_b edge during NMI SERVICE, coincident with int_ack → nmi_pending stays 1 and the next boundary injects again.
- Assert reset mid-SERVICE with an NMI pending → immediate vector_addr = FFFC, int_active = 1, nmi_pending = 0.
